// File: rtl/sorter_pkg.sv
// Shared types for the sorter scheduler: FSM states and requester-id sizing.
package sorter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISCARD,
        WAIT,
        DRAIN,
        FLUSH
    } state_t;

    localparam int DEF_NUM_REQ = 4;

    // Id width that stays legal for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
module rr_arbiter
    import sorter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        // Farthest first, so the nearest requester after ptr overwrites the rest.
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

endmodule

// File: rtl/sorter_scheduler.sv
// Time-shares one systolic sorter among NUM_REQ requesters: load a batch,
// drain the sorted result tagged with the owner id, then reset the sorter.
module sorter_scheduler
    import sorter_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  ELEMENTS      = 64,
    parameter int  BIT_WIDTH     = 32,
    parameter type METADATA_TYPE = logic,
    localparam int ID_W          = id_w(NUM_REQ),
    localparam int CNT_W         = $clog2(ELEMENTS + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]   req_data,
    input  METADATA_TYPE [NUM_REQ-1:0]          req_metadata,
    input  logic [NUM_REQ-1:0]                  req_last,
    output logic                                s_rst,
    output logic                                s_in_valid,
    output logic [BIT_WIDTH-1:0]                s_in_data,
    output METADATA_TYPE                        s_in_metadata,
    output logic                                s_in_last,
    input  logic                                s_out_valid,
    input  logic [BIT_WIDTH-1:0]                s_out_data,
    input  METADATA_TYPE                        s_out_metadata,
    output logic                                s_out_ready,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [BIT_WIDTH-1:0]                res_data,
    output METADATA_TYPE                        res_metadata,
    output logic                                res_last,
    output logic [ID_W-1:0]                     res_id,
    output logic                                busy,
    output logic                                overflow
);

    state_t          state;
    logic [ID_W-1:0] gnt, ptr, arb_id;
    logic [CNT_W-1:0] cnt;
    logic            arb_valid, flush_2nd, at_cap;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    assign at_cap = (cnt == CNT_W'(ELEMENTS - 1));

    // Handshake strobes are masked by rst so an abort is visible immediately.
    always_comb begin
        req_ready = '0;
        if (!rst && (state == LOAD || state == DISCARD))
            req_ready[gnt] = 1'b1;
    end

    assign s_rst        = rst | (state == FLUSH);
    assign busy         = (state != IDLE);
    assign s_out_ready  = !rst && (state == DRAIN) && res_ready;
    assign res_valid    = !rst && (state == DRAIN) && s_out_valid;
    assign res_data     = s_out_data;
    assign res_metadata = s_out_metadata;
    assign res_last     = (state == DRAIN) && (cnt == CNT_W'(1));
    assign res_id       = gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            gnt           <= '0;
            cnt           <= '0;
            flush_2nd     <= 1'b0;
            overflow      <= 1'b0;
            s_in_valid    <= 1'b0;
            s_in_last     <= 1'b0;
            s_in_data     <= '0;
            s_in_metadata <= '0;
        end else begin
            s_in_valid <= 1'b0;
            s_in_last  <= 1'b0;
            case (state)
                IDLE: if (arb_valid) begin
                    gnt   <= arb_id;
                    cnt   <= '0;
                    state <= LOAD;
                end
                LOAD: if (req_valid[gnt]) begin
                    s_in_valid    <= 1'b1;
                    s_in_data     <= req_data[gnt];
                    s_in_metadata <= req_metadata[gnt];
                    s_in_last     <= req_last[gnt] | at_cap;
                    cnt           <= cnt + 1'b1;
                    if (req_last[gnt]) begin
                        state <= WAIT;
                    end else if (at_cap) begin
                        overflow <= 1'b1;
                        state    <= DISCARD;
                    end
                end
                DISCARD: if (req_valid[gnt] && req_last[gnt]) state <= WAIT;
                WAIT:    if (s_out_valid) state <= DRAIN;
                DRAIN: if (s_out_valid && res_ready) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= FLUSH;
                        flush_2nd <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Sorter's end-of-batch latch only clears on reset: hold it two cycles.
                    flush_2nd <= 1'b1;
                    if (flush_2nd) begin
                        ptr   <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_scheduler.sv
// Bench for sorter_scheduler with a behavioural stable sorter on the s_* side.
module tb_sorter_scheduler;
    localparam int NR = 4;
    localparam int E  = 4;
    localparam int BW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR-1:0]           req_valid, req_ready, req_last;
    logic [NR-1:0][BW-1:0]   req_data;
    logic [NR-1:0][3:0]      req_metadata;
    logic                    s_rst, s_in_valid, s_in_last, s_out_valid, s_out_ready;
    logic [BW-1:0]           s_in_data, s_out_data, res_data;
    logic [3:0]              s_in_metadata, s_out_metadata, res_metadata;
    logic                    res_valid, res_ready, res_last, busy, overflow;
    logic [1:0]              res_id;

    sorter_scheduler #(.NUM_REQ(NR), .ELEMENTS(E), .BIT_WIDTH(BW), .METADATA_TYPE(logic [3:0])) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_metadata(req_metadata), .req_last(req_last), .s_rst(s_rst), .s_in_valid(s_in_valid),
        .s_in_data(s_in_data), .s_in_metadata(s_in_metadata), .s_in_last(s_in_last),
        .s_out_valid(s_out_valid), .s_out_data(s_out_data), .s_out_metadata(s_out_metadata),
        .s_out_ready(s_out_ready), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_metadata(res_metadata), .res_last(res_last), .res_id(res_id), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Result backpressure: free-running 1,0,0,1 pattern when enabled.
    logic       bp_mode = 1'b0;
    logic [1:0] bp_cnt  = 2'd0;
    logic [3:0] bp_pat  = 4'b1001;
    always @(posedge clk) bp_cnt <= bp_cnt + 2'd1;
    assign res_ready = !bp_mode || bp_pat[bp_cnt];

    // Sorter model: collect until last, wait, then emit in stable ascending order.
    logic [BW-1:0] mem_d [E];
    logic [3:0]    mem_m [E];
    int mn = 0, mpos = 0, mphase = 0, mtimer = 0, sel;
    always @(posedge clk) begin
        if (s_rst) begin
            mn <= 0; mpos <= 0; mphase <= 0; mtimer <= 0;
        end else begin
            case (mphase)
                0: if (s_in_valid) begin
                    if (mn < E) begin mem_d[mn] <= s_in_data; mem_m[mn] <= s_in_metadata; end
                    mn <= mn + 1;
                    if (s_in_last) mphase <= 1;
                end
                1: if (mtimer == E + 1) mphase <= 2; else mtimer <= mtimer + 1;
                2: if (s_out_ready) begin
                    mpos <= mpos + 1;
                    if (mpos == mn - 1) mphase <= 3;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        int r;
        r = 0; sel = 0;
        for (int j = 0; j < E; j++) begin
            r = 0;
            for (int i = 0; i < E; i++)
                if (i < mn && j < mn && (mem_d[i] < mem_d[j] || (mem_d[i] == mem_d[j] && i < j))) r++;
            if (j < mn && r == mpos) sel = j;
        end
    end
    assign s_out_valid    = (mphase == 2);
    assign s_out_data     = mem_d[sel];
    assign s_out_metadata = mem_m[sel];

    typedef struct packed {
        logic [1:0]  id;
        logic        last;
        logic [3:0]  meta;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          id;
        int          n;
        logic [31:0] din [8];
        int          stall_at;
        int          nexp;
        logic [31:0] dexp [4];
        logic        ovf;
        logic        bp;
    } job_t;

    exp_t  sb[$];
    job_t  jobs [5];
    int    nchk = 0, nerr = 0, srst_cnt = 0, hs_cnt = 0;
    logic  held_v = 1'b0;
    logic [35:0] held;

    function automatic logic [3:0] mf(input logic [31:0] d);
        return d[3:0] ^ 4'h5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        if (s_rst && !rst) srst_cnt++;
        if (res_valid && held_v) chk("stall_stable", {28'd0, res_metadata, res_data}, {28'd0, held});
        held_v = res_valid && !res_ready;
        held   = {res_metadata, res_data};
        if (res_valid && res_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL unexpected_beat: got data %0d id %0d expected none", res_data, res_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat", {25'd0, res_id, res_last, res_metadata, res_data}, {25'd0, e});
            end
        end
    endtask

    task automatic push_exp(input int id, input int npush, input int total, input logic [31:0] a [4]);
        for (int k = 0; k < npush; k++)
            sb.push_back('{id: 2'(id), last: (k == total - 1), meta: mf(a[k]), data: a[k]});
    endtask

    task automatic send(input int id, input int n, input logic [31:0] d [8], input int stall_at);
        logic hs;
        int   w;
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                req_valid[id] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            req_valid[id] = 1'b1; req_data[id] = d[k];
            req_metadata[id] = mf(d[k]); req_last[id] = (k == n - 1);
            w = 0;
            do begin
                @(negedge clk); hs = req_ready[id];
                @(posedge clk); #1; w++;
            end while (!hs && w < 300);
            if (!hs) begin
                nchk++; nerr++;
                $display("FAIL send_timeout: got no req_ready[%0d] expected a grant", id);
            end
        end
        req_valid[id] = 1'b0; req_last[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (busy && w < 400);
        if (busy) begin
            nchk++; nerr++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_rst",       s_rst,       1);
        chk("rst_req_ready",   req_ready,   0);
        chk("rst_s_in_valid",  s_in_valid,  0);
        chk("rst_s_in_last",   s_in_last,   0);
        chk("rst_s_out_ready", s_out_ready, 0);
        chk("rst_res_valid",   res_valid,   0);
        chk("rst_res_last",    res_last,    0);
        chk("rst_busy",        busy,        0);
        chk("rst_overflow",    overflow,    0);
        chk("rst_res_id",      res_id,      0);
    endtask

    initial begin
        logic [31:0] da [8], db [8], ex [4];
        int base;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; req_metadata = '0;

        jobs[0] = '{id: 0, n: 4, din: '{5, 3, 9, 1, 0, 0, 0, 0}, stall_at: -1, nexp: 4,
                    dexp: '{1, 3, 5, 9}, ovf: 1'b0, bp: 1'b0};
        jobs[1] = '{id: 1, n: 6, din: '{8, 7, 6, 5, 4, 3, 0, 0}, stall_at: -1, nexp: 4,
                    dexp: '{5, 6, 7, 8}, ovf: 1'b1, bp: 1'b0};
        jobs[2] = '{id: 3, n: 3, din: '{20, 10, 15, 0, 0, 0, 0, 0}, stall_at: 2, nexp: 3,
                    dexp: '{10, 15, 20, 0}, ovf: 1'b1, bp: 1'b0};
        jobs[3] = '{id: 2, n: 1, din: '{42, 0, 0, 0, 0, 0, 0, 0}, stall_at: -1, nexp: 1,
                    dexp: '{42, 0, 0, 0}, ovf: 1'b1, bp: 1'b0};
        jobs[4] = '{id: 0, n: 4, din: '{4, 7, 2, 4, 0, 0, 0, 0}, stall_at: -1, nexp: 4,
                    dexp: '{2, 4, 4, 7}, ovf: 1'b1, bp: 1'b1};

        fork
            forever begin @(negedge clk); mon(); end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;

        foreach (jobs[j]) begin
            bp_mode = jobs[j].bp;
            base = srst_cnt;
            push_exp(jobs[j].id, jobs[j].nexp, jobs[j].nexp, jobs[j].dexp);
            send(jobs[j].id, jobs[j].n, jobs[j].din, jobs[j].stall_at);
            wait_idle();
            chk("srst_pulse", 64'(srst_cnt - base), 2);
            chk("sb_drained", 64'(sb.size()), 0);
            chk("overflow", overflow, jobs[j].ovf);
            bp_mode = 1'b0;
        end

        // Abort during DRAIN after two of four beats.
        da = '{40, 10, 30, 20, 0, 0, 0, 0};
        ex = '{10, 20, 30, 40};
        push_exp(2, 2, 4, ex);
        base = hs_cnt;
        send(2, 4, da, -1);
        for (int w = 0; w < 300 && hs_cnt < base + 2; w++) begin @(posedge clk); #1; end
        chk("abort_beats", 64'(hs_cnt - base), 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_tail", 64'(sb.size()), 0);
        chk("abort_hs_count", 64'(hs_cnt - base), 2);

        // Round-robin from reset: req0 before req2, then req1 before req0.
        da = '{11, 2, 0, 0, 0, 0, 0, 0};  ex = '{2, 11, 0, 0};  push_exp(0, 2, 2, ex);
        db = '{6, 5, 0, 0, 0, 0, 0, 0};   ex = '{5, 6, 0, 0};   push_exp(2, 2, 2, ex);
        fork
            send(0, 2, da, -1);
            send(2, 2, db, -1);
        join
        wait_idle();
        chk("rr_a_drained", 64'(sb.size()), 0);
        da = '{1, 0, 0, 0, 0, 0, 0, 0};   ex = '{1, 0, 0, 0};   push_exp(0, 1, 1, ex);
        send(0, 1, da, -1);
        wait_idle();
        db = '{4, 3, 0, 0, 0, 0, 0, 0};   ex = '{3, 4, 0, 0};   push_exp(1, 2, 2, ex);
        da = '{9, 8, 0, 0, 0, 0, 0, 0};   ex = '{8, 9, 0, 0};   push_exp(0, 2, 2, ex);
        fork
            send(0, 2, da, -1);
            send(1, 2, db, -1);
        join
        wait_idle();
        chk("rr_b_drained", 64'(sb.size()), 0);
        chk("final_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
